xswitch_port_sink: RTL and testbench

XSWITCH_PORT_SINK -- requirements
Module: xswitch_port_sink

---
 rtl/xswitch_port_sink_if.sv | 52 +++++
 rtl/xswitch_port_sink.sv | 125 ++++++++++++
 tb/tb_xswitch_port_sink.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/xswitch_port_sink_if.sv
// ---------------------------------------------------------------------------
// xswitch_port_sink_if
// Bundles everything between one crossbar output port, the sink FIFO and the
// downstream consumer into one interface so the sink has a compact port list.
//
// Signals
//   addr_out/data_out/valid_out : word presented by the switch output port
//   data_rd                     : sink accepts the presented word this cycle
//   pkt_valid/pkt_addr/pkt_data : FIFO head word offered to the consumer
//   pkt_ready                   : consumer takes the head word this cycle
//   level                       : FIFO occupancy
//   rx_cnt/misroute_cnt         : accepted-word counters (matching/mismatching)
//   misroute_err                : sticky misroute flag
//   clr_cnt                     : synchronous clear of counters and flag
//
// Modports
//   slave  : the sink itself
//   master : the environment (switch port + consumer + control)
// ---------------------------------------------------------------------------
interface xswitch_port_sink_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] addr_out;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              data_rd;
  logic              pkt_valid;
  logic [ADDR_W-1:0] pkt_addr;
  logic [DATA_W-1:0] pkt_data;
  logic              pkt_ready;
  logic [LVL_W-1:0]  level;
  logic [15:0]       rx_cnt;
  logic [15:0]       misroute_cnt;
  logic              misroute_err;
  logic              clr_cnt;

  modport slave (
    input  addr_out, data_out, valid_out, pkt_ready, clr_cnt,
    output data_rd, pkt_valid, pkt_addr, pkt_data, level,
           rx_cnt, misroute_cnt, misroute_err
  );

  modport master (
    output addr_out, data_out, valid_out, pkt_ready, clr_cnt,
    input  data_rd, pkt_valid, pkt_addr, pkt_data, level,
           rx_cnt, misroute_cnt, misroute_err
  );
endinterface

// File: rtl/xswitch_port_sink.sv
// ---------------------------------------------------------------------------
// xswitch_port_sink
// Terminates one crossbar output port. Words whose low two address bits match
// PORT_ID are queued in a first-word-fall-through FIFO for the consumer;
// mismatching words are still drained from the switch but dropped, counted
// and flagged as misroutes.
//
// Ports
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : xswitch_port_sink_if.slave (switch side, consumer side, status)
// ---------------------------------------------------------------------------
module xswitch_port_sink #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int PORT_ID = 0,
  parameter int DEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset,
  xswitch_port_sink_if.slave  bus
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam logic [1:0]       PORT_SEL = PORT_ID[1:0];
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] head;
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [15:0]        rxCnt_q, rxCnt_d;
  logic [15:0]        misCnt_q, misCnt_d;
  logic               misErr_q, misErr_d;
  logic               full, empty, accept, match, push, pop;

  // Handshake decode. Acceptance depends only on the registered level, so a
  // pop in the same cycle never frees a slot for the switch; it retries.
  // Gating with reset keeps data_rd low while reset is held.
  always_comb begin
    full   = (level_q == FULL_LVL);
    empty  = (level_q == '0);
    accept = bus.valid_out & ~full & ~reset;
    match  = (bus.addr_out[1:0] == PORT_SEL);
    push   = accept & match;
    pop    = ~empty & bus.pkt_ready;
  end

  // Next-state for pointers, occupancy and statistics. Pointers wrap
  // naturally because DEPTH is a power of two. Counters saturate, and a
  // clear request overrides any increment in the same cycle.
  always_comb begin
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    level_d  = level_q;
    rxCnt_d  = rxCnt_q;
    misCnt_d = misCnt_q;
    misErr_d = misErr_q;

    if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (bus.clr_cnt) begin
      rxCnt_d  = '0;
      misCnt_d = '0;
      misErr_d = 1'b0;
    end else if (accept) begin
      if (match) begin
        if (rxCnt_q != 16'hFFFF) rxCnt_d = rxCnt_q + 16'd1;
      end else begin
        if (misCnt_q != 16'hFFFF) misCnt_d = misCnt_q + 16'd1;
        misErr_d = 1'b1;
      end
    end
  end

  // Control and status registers. Reset empties the FIFO by clearing the
  // pointers and level; stale storage contents are simply ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      level_q  <= '0;
      rxCnt_q  <= '0;
      misCnt_q <= '0;
      misErr_q <= 1'b0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      level_q  <= level_d;
      rxCnt_q  <= rxCnt_d;
      misCnt_q <= misCnt_d;
      misErr_q <= misErr_d;
    end
  end

  // FIFO storage has no reset; only entries between the pointers are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= {bus.addr_out, bus.data_out};
  end

  // Head word is forced to zero whenever nothing is queued.
  always_comb begin
    head = empty ? '0 : mem_q[rdPtr_q];
  end

  assign bus.data_rd      = accept;
  assign bus.pkt_valid    = ~empty;
  assign bus.pkt_addr     = head[ENTRY_W-1:DATA_W];
  assign bus.pkt_data     = head[DATA_W-1:0];
  assign bus.level        = level_q;
  assign bus.rx_cnt       = rxCnt_q;
  assign bus.misroute_cnt = misCnt_q;
  assign bus.misroute_err = misErr_q;

endmodule

// File: tb/tb_xswitch_port_sink.sv
// ---------------------------------------------------------------------------
// tb_xswitch_port_sink
// Self-checking bench for xswitch_port_sink with PORT_ID=2, DEPTH=4.
// Accepted matching words go into a scoreboard queue; popped words are
// compared against its front.
// ---------------------------------------------------------------------------
module tb_xswitch_port_sink;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;

  xswitch_port_sink_if #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH)) bus ();

  xswitch_port_sink #(
    .DATA_W(8), .ADDR_W(8), .PORT_ID(2), .DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] mQ[$];
  logic [15:0] mRx;
  logic [15:0] mMis;
  logic        mErr;

  // Per-cycle observations captured by applyStimulus
  logic        obsRd, expRd, popped;
  logic [15:0] obsPop, expPop;

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog");
  end

  // Drives one cycle of inputs, captures pre-edge outputs, advances the
  // reference model and returns 1 time unit after the rising edge.
  task automatic applyStimulus(input logic v, input logic [7:0] a,
                               input logic [7:0] d, input logic r,
                               input logic c);
    logic matchL;
    bus.valid_out = v;
    bus.addr_out  = a;
    bus.data_out  = d;
    bus.pkt_ready = r;
    bus.clr_cnt   = c;
    #1;
    matchL = (a[1:0] == 2'd2);
    expRd  = v && (mQ.size() != DEPTH);
    obsRd  = bus.data_rd;
    popped = r && (mQ.size() != 0);
    obsPop = {bus.pkt_addr, bus.pkt_data};
    expPop = 16'h0000;
    if (popped) expPop = mQ.pop_front();
    if (expRd && matchL) mQ.push_back({a, d});
    if (c) begin
      mRx = 16'h0; mMis = 16'h0; mErr = 1'b0;
    end else if (expRd) begin
      if (matchL) begin
        if (mRx != 16'hFFFF) mRx = mRx + 16'd1;
      end else begin
        if (mMis != 16'hFFFF) mMis = mMis + 16'd1;
        mErr = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.valid_out = 1'b1; bus.addr_out = 8'h02; bus.data_out = 8'h11;
    bus.pkt_ready = 1'b0; bus.clr_cnt = 1'b0;
    #1 reset = 1'b1;
    #2;
    checks++; if (bus.data_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_data_rd: got %b expected 0", bus.data_rd); end
    checks++; if (bus.pkt_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_pkt_valid: got %b expected 0", bus.pkt_valid); end
    checks++; if (bus.level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", bus.level); end
    checks++; if ({bus.rx_cnt, bus.misroute_cnt} !== 32'h0) begin errors++; $display("[TB] FAIL reset_counters: got %h/%h expected 0/0", bus.rx_cnt, bus.misroute_cnt); end
    checks++; if ({bus.misroute_err, bus.pkt_addr, bus.pkt_data} !== 17'h0) begin errors++; $display("[TB] FAIL reset_outputs: got err=%b addr=%h data=%h expected zeros", bus.misroute_err, bus.pkt_addr, bus.pkt_data); end
    @(posedge clk);
    @(negedge clk);
    bus.valid_out = 1'b0;
    reset = 1'b0;
    mQ.delete(); mRx = 16'h0; mMis = 16'h0; mErr = 1'b0;
  endtask

  task automatic test_match();
    applyStimulus(1'b1, 8'h02, 8'hA5, 1'b0, 1'b0);
    checks++; if (obsRd !== 1'b1) begin errors++; $display("[TB] FAIL match_data_rd: got %b expected 1", obsRd); end
    checks++; if ({bus.pkt_valid, bus.pkt_addr, bus.pkt_data} !== 17'h102A5) begin errors++; $display("[TB] FAIL match_head: got v=%b %h/%h expected v=1 02/A5", bus.pkt_valid, bus.pkt_addr, bus.pkt_data); end
    checks++; if (bus.level !== 3'd1) begin errors++; $display("[TB] FAIL match_level: got %0d expected 1", bus.level); end
    checks++; if (bus.rx_cnt !== 16'd1) begin errors++; $display("[TB] FAIL match_rx_cnt: got %0d expected 1", bus.rx_cnt); end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    checks++; if (obsPop !== 16'h02A5 || expPop !== 16'h02A5) begin errors++; $display("[TB] FAIL match_pop: got %h expected 02A5", obsPop); end
    checks++; if (bus.level !== 3'd0) begin errors++; $display("[TB] FAIL match_level_after_pop: got %0d expected 0", bus.level); end
  endtask

  task automatic test_misroute();
    applyStimulus(1'b1, 8'h01, 8'h33, 1'b0, 1'b0);
    checks++; if (obsRd !== 1'b1) begin errors++; $display("[TB] FAIL misroute_data_rd: got %b expected 1", obsRd); end
    checks++; if (bus.level !== 3'd0) begin errors++; $display("[TB] FAIL misroute_level: got %0d expected 0", bus.level); end
    checks++; if (bus.misroute_cnt !== 16'd1 || bus.misroute_err !== 1'b1) begin errors++; $display("[TB] FAIL misroute_flag: got cnt=%0d err=%b expected cnt=1 err=1", bus.misroute_cnt, bus.misroute_err); end
    checks++; if (bus.rx_cnt !== mRx) begin errors++; $display("[TB] FAIL misroute_rx_cnt: got %0d expected %0d", bus.rx_cnt, mRx); end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checks++; if ({bus.misroute_cnt, bus.misroute_err, bus.rx_cnt} !== 33'h0) begin errors++; $display("[TB] FAIL clr_cnt: got mis=%0d err=%b rx=%0d expected zeros", bus.misroute_cnt, bus.misroute_err, bus.rx_cnt); end
    // Clear wins over a same-cycle misroute
    applyStimulus(1'b1, 8'h03, 8'h44, 1'b0, 1'b1);
    checks++; if (obsRd !== 1'b1 || bus.misroute_cnt !== 16'd0 || bus.misroute_err !== 1'b0) begin errors++; $display("[TB] FAIL clr_wins: got rd=%b mis=%0d err=%b expected rd=1 mis=0 err=0", obsRd, bus.misroute_cnt, bus.misroute_err); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, {i[5:0], 2'b10}, 8'h10 + 8'(i), 1'b0, 1'b0);
      checks++; if (obsRd !== expRd) begin errors++; $display("[TB] FAIL full_data_rd_%0d: got %b expected %b", i, obsRd, expRd); end
    end
    checks++; if (obsRd !== 1'b0 || bus.level !== 3'd4) begin errors++; $display("[TB] FAIL full_state: got rd=%b level=%0d expected rd=0 level=4", obsRd, bus.level); end
    // Pop while full: switch still refused this cycle
    applyStimulus(1'b1, 8'h12, 8'h14, 1'b1, 1'b0);
    checks++; if (obsRd !== 1'b0) begin errors++; $display("[TB] FAIL full_pop_data_rd: got %b expected 0", obsRd); end
    checks++; if (obsPop !== expPop) begin errors++; $display("[TB] FAIL full_pop0: got %h expected %h", obsPop, expPop); end
    applyStimulus(1'b1, 8'h12, 8'h14, 1'b0, 1'b0);
    checks++; if (obsRd !== 1'b1 || bus.level !== 3'd4) begin errors++; $display("[TB] FAIL full_retry: got rd=%b level=%0d expected rd=1 level=4", obsRd, bus.level); end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      checks++; if (obsPop !== expPop) begin errors++; $display("[TB] FAIL full_drain_%0d: got %h expected %h", i, obsPop, expPop); end
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, 8'h06, 8'hB0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0A, 8'hB1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, {i[5:0], 2'b10}, 8'hC0 + 8'(i), 1'b1, 1'b0);
      checks++; if (obsPop !== expPop) begin errors++; $display("[TB] FAIL b2b_pop_%0d: got %h expected %h", i, obsPop, expPop); end
      checks++; if (bus.level !== 3'd2) begin errors++; $display("[TB] FAIL b2b_level_%0d: got %0d expected 2", i, bus.level); end
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      checks++; if (obsPop !== expPop) begin errors++; $display("[TB] FAIL b2b_drain_%0d: got %h expected %h", i, obsPop, expPop); end
    end
  endtask

  task automatic test_empty_pop();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    checks++; if ({bus.level, bus.pkt_valid, bus.pkt_addr, bus.pkt_data} !== 20'h0) begin errors++; $display("[TB] FAIL empty_pop: got level=%0d v=%b %h/%h expected all 0", bus.level, bus.pkt_valid, bus.pkt_addr, bus.pkt_data); end
    applyStimulus(1'b1, 8'h02, 8'h77, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    checks++; if (obsPop !== 16'h0277 || expPop !== 16'h0277) begin errors++; $display("[TB] FAIL empty_then_push: got %h expected 0277", obsPop); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h0E, 8'hE0 + 8'(i), 1'b0, 1'b0);
    checks++; if (bus.level !== 3'd3) begin errors++; $display("[TB] FAIL areset_preload: got %0d expected 3", bus.level); end
    bus.valid_out = 1'b1; bus.addr_out = 8'h02; bus.data_out = 8'hEE;
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.pkt_valid !== 1'b0 || bus.data_rd !== 1'b0 || bus.level !== 3'd0) begin errors++; $display("[TB] FAIL areset_fifo: got v=%b rd=%b level=%0d expected 0/0/0", bus.pkt_valid, bus.data_rd, bus.level); end
    checks++; if ({bus.rx_cnt, bus.misroute_cnt, bus.pkt_data} !== 40'h0) begin errors++; $display("[TB] FAIL areset_counters: got rx=%0d mis=%0d data=%h expected zeros", bus.rx_cnt, bus.misroute_cnt, bus.pkt_data); end
    bus.valid_out = 1'b0;
    #1 reset = 1'b0;
    mQ.delete(); mRx = 16'h0; mMis = 16'h0; mErr = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 8'h02, 8'hD0, 1'b0, 1'b0);
    checks++; if (obsRd !== 1'b1 || bus.rx_cnt !== 16'd1) begin errors++; $display("[TB] FAIL areset_first_word: got rd=%b rx=%0d expected rd=1 rx=1", obsRd, bus.rx_cnt); end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    checks++; if (obsPop !== 16'h02D0 || expPop !== 16'h02D0) begin errors++; $display("[TB] FAIL areset_first_pop: got %h expected 02D0", obsPop); end
  endtask

  task automatic test_saturation();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    // One accepted word per edge: push into empty, then push+pop forever
    bus.valid_out = 1'b1; bus.addr_out = 8'h02; bus.data_out = 8'h5A;
    bus.pkt_ready = 1'b1; bus.clr_cnt = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    checks++; if (bus.rx_cnt !== 16'hFFFE) begin errors++; $display("[TB] FAIL sat_preload: got %h expected FFFE", bus.rx_cnt); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.rx_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_rx_cnt: got %h expected FFFF", bus.rx_cnt); end
    bus.valid_out = 1'b0; bus.pkt_ready = 1'b0;
    mQ.delete(); mQ.push_back(16'h025A); mRx = 16'hFFFF;
    checks++; if (bus.level !== 3'd1) begin errors++; $display("[TB] FAIL sat_level: got %0d expected 1", bus.level); end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    checks++; if (obsPop !== expPop) begin errors++; $display("[TB] FAIL sat_pop: got %h expected %h", obsPop, expPop); end
  endtask

  initial begin
    test_reset();
    test_match();
    test_misroute();
    test_full();
    test_back_to_back();
    test_empty_pop();
    test_async_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
